tap_stream_loader: RTL
======================

TAP_STREAM_LOADER -- requirements
Module: tap_stream_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, RAM address width.
REQ-002 SHALL have parameter MIN_SYNC, default 3, minimum count of consecutive $16 bytes before $24.
REQ-003 SHALL have parameter MAX_NAME, default 15, maximum name characters shown on the status line.
REQ-004 SHALL have parameter STATUS_BASE, default 16'hBB80, status-line address of the first name character.
REQ-005 SHALL have parameter RELEASE_CYC, default 16, number of cycles cpu_reset is held after download end.
REQ-006 SHALL have port clk_sys, input, 1 bit: single clock; all logic is on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have ports ioctl_download / ioctl_wr / ioctl_addr / ioctl_data, inputs, 1/1/25/8 bits: HPS byte stream.
REQ-009 SHALL have port ioctl_wait, output, 1 bit: stream back-pressure.
REQ-010 SHALL have ports ram_addr / ram_dout / ram_wr, outputs, ADDR_W/8/1 bits, plus ram_ack, input, 1 bit: RAM write handshake.
REQ-011 SHALL have ports cpu_reset and cpu_enabled, outputs, 1 bit each.
REQ-012 SHALL have ports prog_type, autorun, done and error, outputs, 1 bit each.
REQ-013 SHALL have ports start_addr and end_addr, outputs, ADDR_W bits each: values from the last block header.
REQ-014 SHALL have port block_cnt, output, 8 bits: number of completed blocks.

Function
REQ-015 SHALL implement states IDLE, SYNC, HDR, NAME, DATA, DONE, ERR.
REQ-016 SHALL accept a byte on a cycle where ioctl_download & ioctl_wr & ~busy; bytes offered while busy are not consumed.
REQ-017 SHALL set busy on the cycle after a byte needing a RAM write is accepted, and clear it on the cycle after ram_ack is sampled high; ioctl_wait = busy.
REQ-018 SHALL hold ram_wr high, with ram_addr and ram_dout stable, from the cycle after acceptance until ram_ack is sampled high; at most one write is outstanding.
REQ-019 On the rising edge of ioctl_download: enter SYNC; clear sync count, block_cnt, done and error; set cpu_reset=1 and cpu_enabled=0.
REQ-020 In SYNC: a $16 byte increments the saturating sync count; $24 with count>=MIN_SYNC enters HDR; any other byte clears the count.
REQ-021 HDR SHALL consume exactly 9 bytes: indices 0 and 1 unused; 2 gives prog_type=(byte==$80); 3 gives autorun=(byte!=$00); 4 and 5 give end address high then low; 6 and 7 give start address high then low; 8 unused; then enter NAME.
REQ-022 If end < start at HDR exit, SHALL enter ERR and set error=1.
REQ-023 NAME: a zero byte enters DATA; characters 0..MAX_NAME-1 are written to STATUS_BASE+i; further characters are consumed without any write.
REQ-024 DATA SHALL write end-start+1 bytes to start, start+1, ... inclusive, then increment block_cnt and return to SYNC (multi-block stream).
REQ-025 The single-byte case start=end=$FFFF SHALL write exactly one byte with no address wrap.
REQ-026 On the falling edge of ioctl_download: in SYNC with block_cnt>0, enter DONE with done=1; in any other state, enter ERR with error=1.
REQ-027 cpu_enabled SHALL be 1 whenever ioctl_download is low; cpu_reset SHALL deassert RELEASE_CYC cycles after the falling edge, in both DONE and ERR.
REQ-028 A new rising edge of ioctl_download while busy SHALL first complete the pending write and then restart per REQ-019.
REQ-029 Bytes offered in DONE, ERR or IDLE SHALL be ignored and produce no RAM write.

Reset
REQ-030 Asserting reset SHALL immediately force IDLE, busy=0, ram_wr=0, ram_addr=0, ram_dout=0, cpu_reset=0, cpu_enabled=1, flags=0, start_addr=0, end_addr=0 and block_cnt=0; a pending write is abandoned.

Structure
REQ-031 Package tap_pkg SHALL hold the state enum, the $16/$24 sync constants and the header index constants.
REQ-032 Sub-module tap_ram_writer SHALL own the busy, ram_wr and ram_ack handshake; the parser state machine stays in tap_stream_loader.

Verification
REQ-033 Stream 16 16 16 24 00 00 80 C7 05 03 05 01 00 41 00 AA BB CC, then download low -> status writes BB80=41; RAM writes 0501=AA, 0502=BB, 0503=CC; prog_type=1, autorun=1, done=1, block_cnt=1.
REQ-034 ram_ack delayed 5 cycles per write -> ioctl_wait high throughout each delay; no byte is lost or duplicated.
REQ-035 Two concatenated blocks -> block_cnt=2; start_addr and end_addr report the second header.
REQ-036 Only two sync bytes before $24, or a header with end $0400 < start $0500 -> error=1 and no data write.
REQ-037 20-character name -> exactly 15 writes, BB80..BB8E; data still lands correctly.
REQ-038 reset asserted mid-DATA with ram_wr high -> ram_wr=0 and state IDLE in the same cycle.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared definitions for the TAP stream loader.
//   state_t       parser state encoding
//   SYNC_BYTE     lead-in byte repeated before each block
//   BLOCK_MARK    byte that ends the lead-in and starts a header
//   HDR_*         byte positions inside the 9-byte block header
package tap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SYNC = 3'd1,
        ST_HDR  = 3'd2,
        ST_NAME = 3'd3,
        ST_DATA = 3'd4,
        ST_DONE = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'h16;
    localparam logic [7:0] BLOCK_MARK = 8'h24;

    localparam logic [3:0] HDR_PROG     = 4'd2;
    localparam logic [3:0] HDR_AUTORUN  = 4'd3;
    localparam logic [3:0] HDR_END_HI   = 4'd4;
    localparam logic [3:0] HDR_END_LO   = 4'd5;
    localparam logic [3:0] HDR_START_HI = 4'd6;
    localparam logic [3:0] HDR_START_LO = 4'd7;
    localparam logic [3:0] HDR_LAST     = 4'd8;

endpackage

// File: rtl/tap_stream_loader_if.sv
// Stream and RAM bus of the TAP loader.
//   ioctl_download/wr/addr/data : HPS byte stream into the loader
//   ioctl_wait                  : back-pressure from the loader
//   ram_addr/dout/wr            : RAM write request from the loader
//   ram_ack                     : RAM write acknowledge
// master: host + RAM side; slave: the loader.
interface tap_stream_loader_if #(
    parameter int ADDR_W = 16
);
    logic              ioctl_download;
    logic              ioctl_wr;
    logic [24:0]       ioctl_addr;
    logic [7:0]        ioctl_data;
    logic              ioctl_wait;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic              ram_ack;

    modport master (
        output ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, ram_ack,
        input  ioctl_wait, ram_addr, ram_dout, ram_wr
    );

    modport slave (
        input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_data, ram_ack,
        output ioctl_wait, ram_addr, ram_dout, ram_wr
    );
endinterface

// File: rtl/tap_ram_writer.sv
// Single-outstanding RAM write handshake.
//   clk, rst          : clock, async active-high reset
//   req/req_addr/data : one-cycle write request (only issued when !busy)
//   busy              : write outstanding
//   ram_addr/dout/wr  : held stable until ram_ack is sampled high
//   ram_ack           : acknowledge from RAM
module tap_ram_writer #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [7:0]        req_data,
    output logic              busy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [7:0]        ram_dout,
    output logic              ram_wr,
    input  logic              ram_ack
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_dout <= '0;
        end else if (ram_wr) begin
            if (ram_ack)
                ram_wr <= 1'b0;
        end else if (req) begin
            ram_wr   <= 1'b1;
            ram_addr <= req_addr;
            ram_dout <= req_data;
        end
    end

    assign busy = ram_wr;

endmodule

// File: rtl/tap_stream_loader.sv
// TAP tape-image loader: parses lead-in, header, name and data of each
// block from the HPS byte stream and writes name/data bytes to RAM.
//   clk_sys, reset          : clock, async active-high reset
//   bus (slave)             : byte stream in, RAM write handshake out
//   cpu_reset, cpu_enabled  : CPU hold/enable around a download
//   prog_type, autorun      : flags from the last header
//   done, error             : download outcome
//   start_addr, end_addr    : addresses from the last header
//   block_cnt               : completed blocks
module tap_stream_loader
    import tap_pkg::*;
#(
    parameter int          ADDR_W      = 16,
    parameter int          MIN_SYNC    = 3,
    parameter int          MAX_NAME    = 15,
    parameter logic [15:0] STATUS_BASE = 16'hBB80,
    parameter int          RELEASE_CYC = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    tap_stream_loader_if.slave bus,
    output logic              cpu_reset,
    output logic              cpu_enabled,
    output logic              prog_type,
    output logic              autorun,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] start_addr,
    output logic [ADDR_W-1:0] end_addr,
    output logic [7:0]        block_cnt
);

    localparam logic [7:0]  MIN_SYNC_C = 8'(MIN_SYNC);
    localparam logic [7:0]  MAX_NAME_C = 8'(MAX_NAME);
    localparam logic [15:0] REL_LOAD   = 16'(RELEASE_CYC - 1);

    state_t      state;
    logic        dl_q;
    logic        restart_pend;
    logic        en_q;
    logic        rel_active;
    logic [15:0] rel_cnt;
    logic [7:0]  sync_cnt;
    logic [3:0]  hdr_idx;
    logic [7:0]  name_idx;
    logic [15:0] start_q;
    logic [15:0] end_q;
    logic [15:0] cur_addr;

    logic        busy;
    logic        rise;
    logic        fall;
    logic        do_restart;
    logic        accept;
    logic        wr_req;
    logic [15:0] wr_addr;
    logic [7:0]  byte_in;
    logic        unused_addr;

    assign byte_in     = bus.ioctl_data;
    assign unused_addr = ^bus.ioctl_addr;

    assign rise = bus.ioctl_download & ~dl_q;
    assign fall = ~bus.ioctl_download & dl_q;

    // A rising edge seen while a write is outstanding is remembered and
    // acted upon once the write completes.
    assign do_restart = (rise | restart_pend) & ~busy;

    // No byte is taken on the restart cycle or while a restart is pending.
    assign accept = bus.ioctl_download & bus.ioctl_wr & ~busy & ~rise & ~restart_pend;

    always_comb begin
        wr_req  = 1'b0;
        wr_addr = '0;
        if (accept) begin
            case (state)
                ST_NAME: begin
                    if (byte_in != 8'h00 && name_idx < MAX_NAME_C) begin
                        wr_req  = 1'b1;
                        wr_addr = STATUS_BASE + {8'h00, name_idx};
                    end
                end
                ST_DATA: begin
                    wr_req  = 1'b1;
                    wr_addr = cur_addr;
                end
                default: ;
            endcase
        end
    end

    tap_ram_writer #(
        .ADDR_W(ADDR_W)
    ) u_writer (
        .clk      (clk_sys),
        .rst      (reset),
        .req      (wr_req),
        .req_addr (ADDR_W'(wr_addr)),
        .req_data (byte_in),
        .busy     (busy),
        .ram_addr (bus.ram_addr),
        .ram_dout (bus.ram_dout),
        .ram_wr   (bus.ram_wr),
        .ram_ack  (bus.ram_ack)
    );

    assign bus.ioctl_wait = busy;
    assign cpu_enabled    = ~bus.ioctl_download | en_q;
    assign start_addr     = ADDR_W'(start_q);
    assign end_addr       = ADDR_W'(end_q);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            dl_q         <= 1'b0;
            restart_pend <= 1'b0;
            en_q         <= 1'b1;
            rel_active   <= 1'b0;
            rel_cnt      <= '0;
            cpu_reset    <= 1'b0;
            prog_type    <= 1'b0;
            autorun      <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            sync_cnt     <= '0;
            hdr_idx      <= '0;
            name_idx     <= '0;
            start_q      <= '0;
            end_q        <= '0;
            cur_addr     <= '0;
            block_cnt    <= '0;
        end else begin
            dl_q <= bus.ioctl_download;

            if (rise && busy)
                restart_pend <= 1'b1;

            if (rel_active) begin
                if (rel_cnt == '0) begin
                    cpu_reset  <= 1'b0;
                    rel_active <= 1'b0;
                end else begin
                    rel_cnt <= rel_cnt - 16'd1;
                end
            end

            if (do_restart) begin
                restart_pend <= 1'b0;
                state        <= ST_SYNC;
                sync_cnt     <= '0;
                block_cnt    <= '0;
                done         <= 1'b0;
                error        <= 1'b0;
                cpu_reset    <= 1'b1;
                en_q         <= 1'b0;
                rel_active   <= 1'b0;
            end else if (fall) begin
                en_q       <= 1'b1;
                rel_active <= 1'b1;
                rel_cnt    <= REL_LOAD;
                if (state == ST_SYNC && block_cnt != 8'd0) begin
                    state <= ST_DONE;
                    done  <= 1'b1;
                end else begin
                    state <= ST_ERR;
                    error <= 1'b1;
                end
            end else if (accept) begin
                case (state)
                    ST_SYNC: begin
                        if (byte_in == SYNC_BYTE) begin
                            if (sync_cnt != 8'hFF)
                                sync_cnt <= sync_cnt + 8'd1;
                        end else if (byte_in == BLOCK_MARK && sync_cnt >= MIN_SYNC_C) begin
                            state    <= ST_HDR;
                            hdr_idx  <= '0;
                            sync_cnt <= '0;
                        end else begin
                            sync_cnt <= '0;
                        end
                    end
                    ST_HDR: begin
                        case (hdr_idx)
                            HDR_PROG:     prog_type      <= (byte_in == 8'h80);
                            HDR_AUTORUN:  autorun        <= (byte_in != 8'h00);
                            HDR_END_HI:   end_q[15:8]    <= byte_in;
                            HDR_END_LO:   end_q[7:0]     <= byte_in;
                            HDR_START_HI: start_q[15:8]  <= byte_in;
                            HDR_START_LO: start_q[7:0]   <= byte_in;
                            default: ;
                        endcase
                        if (hdr_idx == HDR_LAST) begin
                            if (end_q < start_q) begin
                                state <= ST_ERR;
                                error <= 1'b1;
                            end else begin
                                state    <= ST_NAME;
                                name_idx <= '0;
                                cur_addr <= start_q;
                            end
                        end else begin
                            hdr_idx <= hdr_idx + 4'd1;
                        end
                    end
                    ST_NAME: begin
                        if (byte_in == 8'h00)
                            state <= ST_DATA;
                        else if (name_idx != 8'hFF)
                            name_idx <= name_idx + 8'd1;
                    end
                    ST_DATA: begin
                        // Compare before incrementing so end=$FFFF never wraps.
                        if (cur_addr == end_q) begin
                            block_cnt <= block_cnt + 8'd1;
                            state     <= ST_SYNC;
                            sync_cnt  <= '0;
                        end else begin
                            cur_addr <= cur_addr + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
